fetch_queue: RTL and testbench

//   Instruction-fetch front end that sits between the instruction ROM and the
//   CPU decode stage. It owns the PC, issues sequential reads to the ROM
//   (synchronous, 1-cycle read latency), and buffers returned words with their
//   PCs in a small FIFO. Decode consumes entries over a valid/ready handshake.
//   A taken branch from decode flushes the FIFO and redirects the PC.

---
 rtl/fetch_queue.sv | 107 ++++++++++
 tb/tb_fetch_queue.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the PC, issues 1-cycle-latency ROM reads and
// buffers returned words with their PCs in a small FIFO drained by decode.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        rom_enable,
  output logic [31:0] rom_address,
  input  logic [31:0] rom_data,
  input  logic        branch_flag,
  input  logic [31:0] branch_address,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instruction,
  output logic [31:0] id_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   r_pc;
  logic [31:0]   r_tag;
  logic          r_inflight;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_mem_ins [DEPTH];
  logic [31:0]   r_mem_pc  [DEPTH];
  logic [31:0]   r_id_ins;
  logic [31:0]   r_id_pc;

  logic [CW-1:0] w_occupancy;
  logic          w_issue;
  logic          w_push;
  logic          w_pop;
  logic [PW-1:0] w_rd_next;
  logic [CW-1:0] w_count_next;
  logic          w_head_from_rom;
  logic [31:0]   w_head_ins;
  logic [31:0]   w_head_pc;
  logic [31:0]   w_target;

  // The in-flight read already owns a slot, so occupancy counts it.
  assign w_occupancy  = r_count + CW'(r_inflight);
  assign w_issue      = (w_occupancy < CW'(DEPTH)) && !branch_flag;
  assign w_push       = r_inflight && !branch_flag;
  assign w_pop        = (r_count != '0) && id_ready && !branch_flag;
  assign w_rd_next    = r_rd_ptr + PW'(w_pop);
  assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);
  assign w_target     = branch_address & 32'hFFFF_FFFC;

  // The word being pushed becomes the head only when nothing else remains.
  assign w_head_from_rom = w_push && (r_count == CW'(w_pop));
  assign w_head_ins      = w_head_from_rom ? rom_data : r_mem_ins[w_rd_next];
  assign w_head_pc       = w_head_from_rom ? r_tag    : r_mem_pc[w_rd_next];

  assign rom_enable     = reset && w_issue;
  assign rom_address    = reset ? r_pc : 32'h0;
  assign id_valid       = (r_count != '0);
  assign id_instruction = r_id_ins;
  assign id_pc          = r_id_pc;

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem_ins[r_wr_ptr] <= rom_data;
      r_mem_pc[r_wr_ptr]  <= r_tag;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pc       <= RESET_PC;
      r_tag      <= 32'h0;
      r_inflight <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_id_ins   <= 32'h0;
      r_id_pc    <= 32'h0;
    end else if (branch_flag) begin
      // Redirect flushes everything, including the word returning this cycle.
      r_pc       <= w_target;
      r_inflight <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_issue) begin
        r_pc  <= r_pc + 32'd4;
        r_tag <= r_pc;
      end
      r_inflight <= w_issue;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      r_rd_ptr <= w_rd_next;
      r_count  <= w_count_next;
      if (w_count_next != '0) begin
        r_id_ins <= w_head_ins;
        r_id_pc  <= w_head_pc;
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table for the fetch/stall/branch/reset
// scenarios, then randomized traffic against a queue-based reference model.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        rom_enable;
  logic [31:0] rom_address;
  logic [31:0] rom_data = 32'h0;
  logic        branch_flag;
  logic [31:0] branch_address;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instruction;
  logic [31:0] id_pc;

  int total = 0;
  int bad   = 0;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clock(clock), .reset(reset),
    .rom_enable(rom_enable), .rom_address(rom_address), .rom_data(rom_data),
    .branch_flag(branch_flag), .branch_address(branch_address),
    .id_ready(id_ready), .id_valid(id_valid),
    .id_instruction(id_instruction), .id_pc(id_pc)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'h1000_0000 + {2'b00, a[31:2]};
  endfunction

  // Synchronous ROM, one-cycle read latency.
  always @(posedge clock) begin
    if (rom_enable) rom_data <= rom_word(rom_address);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit          rst;
    bit          rdy;
    bit          br;
    logic [31:0] baddr;
    bit          en;
    logic [31:0] addr;
    bit          v;
    logic [31:0] pc;
    logic [31:0] ins;
  } vec_t;

  vec_t tbl[64];
  int   n = 0;

  task automatic add(input bit rst, input bit rdy, input bit br, input logic [31:0] baddr,
                     input bit en, input logic [31:0] addr, input bit v,
                     input logic [31:0] pc, input logic [31:0] ins);
    tbl[n] = '{rst, rdy, br, baddr, en, addr, v, pc, ins};
    n++;
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc, m_tag, m_hold_pc, m_hold_ins;
  bit          m_infl;

  task automatic model_reset();
    mq.delete();
    m_pc = 32'h0; m_tag = 32'h0; m_infl = 1'b0;
    m_hold_pc = 32'h0; m_hold_ins = 32'h0;
  endtask

  initial begin
    bit          rst, rdy, br, exp_en;
    logic [31:0] baddr, rd;
    ent_t        e;

    reset = 1'b0; id_ready = 1'b0; branch_flag = 1'b0; branch_address = 32'h0;

    // Reset release, streaming with id_ready=1.
    add(1,0,0,0,            0,32'h0,        0,32'h0,        32'h0);
    add(0,1,0,0,            1,32'h0,        0,32'h0,        32'h0);
    add(0,1,0,0,            1,32'h4,        0,32'h0,        32'h0);
    add(0,1,0,0,            1,32'h8,        1,32'h0,        32'h1000_0000);
    add(0,1,0,0,            1,32'hC,        1,32'h4,        32'h1000_0001);
    add(0,1,0,0,            1,32'h10,       1,32'h8,        32'h1000_0002);
    add(0,1,0,0,            1,32'h14,       1,32'hC,        32'h1000_0003);
    // Reset, then fill with id_ready=0 until full; one pop; full again.
    add(1,0,0,0,            0,32'h0,        0,32'h0,        32'h0);
    add(0,0,0,0,            1,32'h0,        0,32'h0,        32'h0);
    add(0,0,0,0,            1,32'h4,        0,32'h0,        32'h0);
    add(0,0,0,0,            1,32'h8,        1,32'h0,        32'h1000_0000);
    add(0,0,0,0,            1,32'hC,        1,32'h0,        32'h1000_0000);
    add(0,0,0,0,            0,32'h0,        1,32'h0,        32'h1000_0000);
    add(0,0,0,0,            0,32'h0,        1,32'h0,        32'h1000_0000);
    add(0,1,0,0,            0,32'h0,        1,32'h0,        32'h1000_0000);
    add(0,0,0,0,            1,32'h10,       1,32'h4,        32'h1000_0001);
    add(0,0,0,0,            0,32'h0,        1,32'h4,        32'h1000_0001);
    add(0,0,0,0,            0,32'h0,        1,32'h4,        32'h1000_0001);
    // Drain a bit, then branch to 0x103 with a read in flight.
    add(0,1,0,0,            0,32'h0,        1,32'h4,        32'h1000_0001);
    add(0,1,0,0,            1,32'h14,       1,32'h8,        32'h1000_0002);
    add(0,1,1,32'h103,      0,32'h0,        1,32'hC,        32'h1000_0003);
    add(0,1,0,0,            1,32'h100,      0,32'hC,        32'h1000_0003);
    add(0,1,0,0,            1,32'h104,      0,32'hC,        32'h1000_0003);
    add(0,1,0,0,            1,32'h108,      1,32'h100,      32'h1000_0040);
    // Branch near the top of the address space; PC wraps to 0.
    add(0,1,1,32'hFFFF_FFF8,0,32'h0,        1,32'h104,      32'h1000_0041);
    add(0,1,0,0,            1,32'hFFFF_FFF8,0,32'h104,      32'h1000_0041);
    add(0,1,0,0,            1,32'hFFFF_FFFC,0,32'h104,      32'h1000_0041);
    add(0,1,0,0,            1,32'h0,        1,32'hFFFF_FFF8,32'h4FFF_FFFE);
    add(0,1,0,0,            1,32'h4,        1,32'hFFFF_FFFC,32'h4FFF_FFFF);
    add(0,1,0,0,            1,32'h8,        1,32'h0,        32'h1000_0000);
    // Back-to-back branches: the last one wins.
    add(0,1,1,32'h200,      0,32'h0,        1,32'h4,        32'h1000_0001);
    add(0,1,1,32'h300,      0,32'h0,        0,32'h4,        32'h1000_0001);
    add(0,1,0,0,            1,32'h300,      0,32'h4,        32'h1000_0001);
    add(0,1,0,0,            1,32'h304,      0,32'h4,        32'h1000_0001);
    add(0,1,0,0,            1,32'h308,      1,32'h300,      32'h1000_00C0);
    // Partly fill, then reset mid-stream.
    add(0,0,0,0,            1,32'h30C,      1,32'h304,      32'h1000_00C1);
    add(0,0,0,0,            1,32'h310,      1,32'h304,      32'h1000_00C1);
    add(1,0,0,0,            0,32'h0,        0,32'h0,        32'h0);
    add(0,1,0,0,            1,32'h0,        0,32'h0,        32'h0);

    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      reset          = !tbl[i].rst;
      id_ready       = tbl[i].rdy;
      branch_flag    = tbl[i].br;
      branch_address = tbl[i].baddr;
      #1;
      chk($sformatf("row%0d rom_enable", i), {31'b0, rom_enable}, {31'b0, tbl[i].en});
      if (tbl[i].en || tbl[i].rst)
        chk($sformatf("row%0d rom_address", i), rom_address, tbl[i].addr);
      chk($sformatf("row%0d id_valid", i), {31'b0, id_valid}, {31'b0, tbl[i].v});
      chk($sformatf("row%0d id_pc", i), id_pc, tbl[i].pc);
      chk($sformatf("row%0d id_instruction", i), id_instruction, tbl[i].ins);
    end

    // Randomized traffic against the reference model.
    @(negedge clock);
    reset = 1'b0; branch_flag = 1'b0; id_ready = 1'b0;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      rst   = ($urandom_range(0, 199) == 0);
      br    = ($urandom_range(0, 19) == 0);
      rdy   = ($urandom_range(0, 3) != 0);
      baddr = $urandom;
      reset = !rst; branch_flag = br; branch_address = baddr; id_ready = rdy;
      #1;
      rd = rom_data;
      if (rst) begin
        model_reset();
        exp_en = 1'b0;
      end else begin
        exp_en = !br && (mq.size() + int'(m_infl) < DEPTH);
      end
      chk($sformatf("rnd%0d rom_enable", c), {31'b0, rom_enable}, {31'b0, exp_en});
      if (exp_en || rst)
        chk($sformatf("rnd%0d rom_address", c), rom_address, rst ? 32'h0 : m_pc);
      chk($sformatf("rnd%0d id_valid", c), {31'b0, id_valid}, {31'b0, mq.size() != 0});
      chk($sformatf("rnd%0d id_pc", c), id_pc, (mq.size() != 0) ? mq[0].pc : m_hold_pc);
      chk($sformatf("rnd%0d id_instruction", c), id_instruction,
          (mq.size() != 0) ? mq[0].ins : m_hold_ins);
      // Advance the model across the coming edge.
      if (!rst) begin
        if (br) begin
          mq.delete();
          m_infl = 1'b0;
          m_pc   = {baddr[31:2], 2'b00};
        end else begin
          if (mq.size() != 0 && rdy) void'(mq.pop_front());
          if (m_infl) begin
            e.pc = m_tag; e.ins = rd;
            mq.push_back(e);
          end
          m_infl = exp_en;
          if (exp_en) begin
            m_tag = m_pc;
            m_pc  = m_pc + 32'd4;
          end
        end
        if (mq.size() != 0) begin
          m_hold_pc  = mq[0].pc;
          m_hold_ins = mq[0].ins;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
